pipe_chain_ctrl: RTL and testbench

PIPE_CHAIN_CTRL -- requirements
Module: pipe_chain_ctrl

---
 rtl/pipe_chain_ctrl.sv | 99 +++++++++
 tb/tb_pipe_chain_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain_ctrl.sv
// Linear pipeline controller: per-stage valid/data registers with backward stall propagation,
// bubble insertion behind the deepest held stage, flush, and retire/bubble counters.
module pipe_chain_ctrl #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic [STAGES-1:0]          stallreq,
  input  logic                       flush,
  output logic [STAGES-1:0]          stall_o,
  output logic [STAGES-1:0]          stage_valid,
  output logic [STAGES*DATA_W-1:0]   stage_data,
  output logic                       out_fire,
  output logic [DATA_W-1:0]          out_data,
  output logic [CNT_W-1:0]           retire_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
);

  logic [STAGES-1:0] r_valid;
  logic [DATA_W-1:0] r_data [STAGES];
  logic [CNT_W-1:0]  r_retire;
  logic [CNT_W-1:0]  r_bubble;

  logic [STAGES-1:0] w_stall;
  logic              w_accept;
  logic              w_bubble;

  // A stall request from stage j holds every stage at or before j.
  always_comb begin
    w_stall = '0;
    w_stall[STAGES-1] = stallreq[STAGES-1];
    for (int unsigned j = 1; j < STAGES; j++) begin
      w_stall[STAGES-1-j] = stallreq[STAGES-1-j] | w_stall[STAGES-j];
    end
  end

  // Exactly one stage (k+1) receives a bubble whenever some stage other than the last is the deepest held.
  assign w_bubble = w_stall[0] & ~w_stall[STAGES-1] & ~flush;
  assign in_ready = ~w_stall[0] & ~flush & rst;
  assign w_accept = in_valid & in_ready;
  assign out_fire = r_valid[STAGES-1] & ~w_stall[STAGES-1] & ~flush;

  assign stall_o     = w_stall;
  assign stage_valid = r_valid;
  assign out_data    = r_data[STAGES-1];
  assign retire_cnt  = r_retire;
  assign bubble_cnt  = r_bubble;

  always_comb begin
    stage_data = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      stage_data[i*DATA_W +: DATA_W] = r_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
      end
      r_retire <= '0;
      r_bubble <= '0;
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else begin
        if (!w_stall[0]) begin
          r_valid[0] <= w_accept;
          if (w_accept) begin
            r_data[0] <= in_data;
          end
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
          if (!w_stall[i]) begin
            if (w_stall[i-1]) begin
              r_valid[i] <= 1'b0;
            end else begin
              r_valid[i] <= r_valid[i-1];
              r_data[i]  <= r_data[i-1];
            end
          end
        end
      end
      if (out_fire) begin
        r_retire <= r_retire + CNT_W'(1);
      end
      if (w_bubble) begin
        r_bubble <= r_bubble + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_chain_ctrl.sv
// Directed self-checking bench for pipe_chain_ctrl (STAGES=5, DATA_W=32, CNT_W=4 to exercise counter wrap).
module tb_pipe_chain_ctrl;
  localparam int unsigned S  = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic [S-1:0]      stallreq;
  logic              flush;
  logic [S-1:0]      stall_o;
  logic [S-1:0]      stage_valid;
  logic [S*DW-1:0]   stage_data;
  logic              out_fire;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     retire_cnt;
  logic [CW-1:0]     bubble_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  logic [CW-1:0] exp_ret;
  logic [CW-1:0] exp_bub;

  pipe_chain_ctrl #(.STAGES(S), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stallreq(stallreq), .flush(flush), .stall_o(stall_o), .stage_valid(stage_valid),
    .stage_data(stage_data), .out_fire(out_fire), .out_data(out_data),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; stallreq = 5'b00100; flush = 1'b0;
    #3;
    n_cmp++; if (stage_valid !== 5'b0) begin n_mis++; $display("FAIL rst_valid: got %b want %b", stage_valid, 5'b0); end
    n_cmp++; if (stage_data !== '0) begin n_mis++; $display("FAIL rst_data: got %h want 0", stage_data); end
    n_cmp++; if (retire_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin n_mis++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", retire_cnt, bubble_cnt); end
    n_cmp++; if (in_ready !== 1'b0 || out_fire !== 1'b0) begin n_mis++; $display("FAIL rst_hs: got rdy=%b fire=%b want 0/0", in_ready, out_fire); end
    n_cmp++; if (stall_o !== 5'b00111) begin n_mis++; $display("FAIL rst_stall_o: got %b want %b", stall_o, 5'b00111); end
    cyc();
    in_valid = 1'b0; stallreq = '0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    exp_ret = '0; exp_bub = '0;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL single_rdy: got %b want 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (stage_valid !== 5'(1 << i)) begin n_mis++; $display("FAIL single_walk%0d: got %b want %b", i, stage_valid, 5'(1 << i)); end
      if (i < 4) cyc();
    end
    n_cmp++; if (out_fire !== 1'b1 || out_data !== 32'hA5A5_0001) begin n_mis++; $display("FAIL single_out: got fire=%b data=%h want 1/a5a50001", out_fire, out_data); end
    n_cmp++; if (stage_data[4*DW +: DW] !== 32'hA5A5_0001) begin n_mis++; $display("FAIL single_s4: got %h want a5a50001", stage_data[4*DW +: DW]); end
    cyc();
    exp_ret = exp_ret + 4'd1;
    n_cmp++; if (retire_cnt !== exp_ret || stage_valid !== 5'b0) begin n_mis++; $display("FAIL single_ret: got cnt=%0d v=%b want %0d/00000", retire_cnt, stage_valid, exp_ret); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got [$];
    int nxt = 1;
    int cy = 0;
    while (got.size() < 8 && cy < 60) begin
      stallreq = (cy == 4 || cy == 5) ? 5'b00100 : 5'b0;
      in_valid = (nxt <= 8);
      in_data = DW'(nxt);
      #1;
      if (cy == 4 || cy == 5) begin
        n_cmp++; if (stall_o !== 5'b00111 || in_ready !== 1'b0) begin n_mis++; $display("FAIL b2b_stall%0d: got stall_o=%b rdy=%b want 00111/0", cy, stall_o, in_ready); end
      end
      if (in_valid && in_ready) nxt++;
      if (out_fire) got.push_back(out_data);
      cyc();
      if (cy == 4 || cy == 5) begin
        n_cmp++; if (stage_valid[3] !== 1'b0) begin n_mis++; $display("FAIL b2b_bubble%0d: got %b want 0", cy, stage_valid[3]); end
      end
      cy++;
    end
    stallreq = '0; in_valid = 1'b0;
    n_cmp++; if (got.size() != 8) begin n_mis++; $display("FAIL b2b_count: got %0d want 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++; if (got[i] !== DW'(i + 1)) begin n_mis++; $display("FAIL b2b_order%0d: got %h want %h", i, got[i], DW'(i + 1)); end
    end
    exp_ret = exp_ret + 4'd8;
    exp_bub = exp_bub + 4'd2;
    n_cmp++; if (retire_cnt !== exp_ret || bubble_cnt !== exp_bub) begin n_mis++; $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d", retire_cnt, bubble_cnt, exp_ret, exp_bub); end
  endtask

  task automatic test_hold_last();
    in_valid = 1'b1; in_data = 32'h0000_0033;
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    n_cmp++; if (stage_valid !== 5'b10000) begin n_mis++; $display("FAIL hold_fill: got %b want 10000", stage_valid); end
    stallreq = 5'b10000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (out_fire !== 1'b0 || stage_data[4*DW +: DW] !== 32'h33 || stall_o !== 5'b11111) begin
        n_mis++; $display("FAIL hold_c%0d: got fire=%b s4=%h stall_o=%b want 0/33/11111", i, out_fire, stage_data[4*DW +: DW], stall_o);
      end
      cyc();
    end
    stallreq = '0;
    #1;
    n_cmp++; if (out_fire !== 1'b1 || out_data !== 32'h33) begin n_mis++; $display("FAIL hold_release: got fire=%b data=%h want 1/33", out_fire, out_data); end
    cyc();
    exp_ret = exp_ret + 4'd1;
    n_cmp++; if (retire_cnt !== exp_ret || bubble_cnt !== exp_bub || stage_valid !== 5'b0) begin
      n_mis++; $display("FAIL hold_once: got %0d/%0d v=%b want %0d/%0d/00000", retire_cnt, bubble_cnt, stage_valid, exp_ret, exp_bub);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = DW'(32'h10 + k);
      cyc();
    end
    n_cmp++; if (stage_valid !== 5'b11111) begin n_mis++; $display("FAIL flush_fill: got %b want 11111", stage_valid); end
    flush = 1'b1; stallreq = 5'b00010; in_valid = 1'b1; in_data = 32'hFF;
    #1;
    n_cmp++; if (in_ready !== 1'b0 || out_fire !== 1'b0 || stall_o !== 5'b00011) begin
      n_mis++; $display("FAIL flush_comb: got rdy=%b fire=%b stall_o=%b want 0/0/00011", in_ready, out_fire, stall_o);
    end
    cyc();
    flush = 1'b0; stallreq = '0; in_valid = 1'b0;
    #1;
    n_cmp++; if (stage_valid !== 5'b0) begin n_mis++; $display("FAIL flush_valid: got %b want 00000", stage_valid); end
    n_cmp++; if (stage_data[0 +: DW] !== 32'h14 || stage_data[4*DW +: DW] !== 32'h10) begin
      n_mis++; $display("FAIL flush_data: got s0=%h s4=%h want 14/10", stage_data[0 +: DW], stage_data[4*DW +: DW]);
    end
    n_cmp++; if (retire_cnt !== exp_ret || bubble_cnt !== exp_bub) begin n_mis++; $display("FAIL flush_cnt: got %0d/%0d want %0d/%0d", retire_cnt, bubble_cnt, exp_ret, exp_bub); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 32'h77;
    cyc();
    in_valid = 1'b0;
    cyc();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (stage_valid !== 5'b0 || stage_data !== '0) begin n_mis++; $display("FAIL arst_state: got v=%b d=%h want 0/0", stage_valid, stage_data); end
    n_cmp++; if (retire_cnt !== 4'd0 || bubble_cnt !== 4'd0 || in_ready !== 1'b0) begin
      n_mis++; $display("FAIL arst_cnt: got %0d/%0d rdy=%b want 0/0/0", retire_cnt, bubble_cnt, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_ret = '0; exp_bub = '0;
    cyc();
    in_valid = 1'b1; in_data = 32'h55;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (out_fire !== 1'b0) begin n_mis++; $display("FAIL arst_early%0d: got %b want 0", i, out_fire); end
    end
    cyc();
    n_cmp++; if (out_fire !== 1'b1 || out_data !== 32'h55) begin n_mis++; $display("FAIL arst_lat: got fire=%b data=%h want 1/55", out_fire, out_data); end
    cyc();
  endtask

  task automatic test_wrap();
    int nxt = 1;
    int got = 0;
    int cy = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    cyc();
    while (got < 17 && cy < 80) begin
      in_valid = (nxt <= 17);
      in_data = DW'(nxt);
      #1;
      if (in_valid && in_ready) nxt++;
      if (out_fire) got++;
      cyc();
      cy++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 17) begin n_mis++; $display("FAIL wrap_count: got %0d want 17", got); end
    n_cmp++; if (retire_cnt !== 4'd1 || bubble_cnt !== 4'd0) begin n_mis++; $display("FAIL wrap_cnt: got %0d/%0d want 1/0", retire_cnt, bubble_cnt); end
  endtask

  initial begin
    exp_ret = '0; exp_bub = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_last();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
